// File: rtl/imem_loader.sv
// imem_loader
//
// Loads a program into the instruction memory from a framed byte stream.
// The frame is a 2-byte word count (LSB first) followed by count*4 data bytes.
// The data bytes form little-endian 32-bit words, which are written to
// consecutive word addresses starting at 0. The core is held in reset
// (core_hold) while a session is in progress.
//
// Ports:
//   clock       system clock, rising edge
//   clear       asynchronous active-high reset
//   start       pulse; opens a load session from idle, done or error
//   byte_in     stream data byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte this cycle (registered)
//   mem_addr    instruction memory byte address, word aligned
//   mem_din     word to write, {b3,b2,b1,b0}
//   mem_wren    write strobe, one cycle per word
//   core_hold   drives the core clear; high while a session is active
//   done        load completed; sticky until the next start
//   error       header word count exceeds capacity; sticky until the next start
//
// LEN_WIDTH must be at least 8; the header always carries 16 bits.

module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic                  mem_wren,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned WIDX_W   = ADDR_WIDTH - 2;
    localparam int unsigned CAPACITY = 2 ** WIDX_W;

    typedef enum logic [2:0] {
        StIdle,
        StLenLo,
        StLenHi,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e               state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] word_idx_q;
    logic [1:0]           byte_idx_q;
    logic [23:0]          lanes_q;

    logic                 accept;
    logic [15:0]          hdr;
    logic                 hdr_too_big;
    logic [LEN_WIDTH-1:0] word_idx_inc;

    assign accept       = byte_valid && byte_ready;
    // Full header as it stands while the high byte is on byte_in.
    assign hdr          = {byte_in, len_q[7:0]};
    assign hdr_too_big  = 32'(hdr) > CAPACITY;
    assign word_idx_inc = word_idx_q + LEN_WIDTH'(1);

    // Single registered FSM; every output is a flop updated on the transition
    // into the state that owns it, so outputs never glitch with inputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q    <= StIdle;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            lanes_q    <= '0;
            byte_ready <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_wren   <= 1'b0;
            core_hold  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            // Strobe is only ever raised for the single WRITE cycle.
            mem_wren <= 1'b0;

            unique case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state_q    <= StLenLo;
                        byte_ready <= 1'b1;
                        core_hold  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_idx_q <= '0;
                        byte_idx_q <= '0;
                    end
                end

                StLenLo: begin
                    if (accept) begin
                        len_q[7:0] <= byte_in;
                        state_q    <= StLenHi;
                    end
                end

                StLenHi: begin
                    if (accept) begin
                        len_q <= LEN_WIDTH'(hdr);
                        if (hdr == 16'd0) begin
                            state_q    <= StDone;
                            byte_ready <= 1'b0;
                            core_hold  <= 1'b0;
                            done       <= 1'b1;
                        end else if (hdr_too_big) begin
                            state_q    <= StErr;
                            byte_ready <= 1'b0;
                            core_hold  <= 1'b0;
                            error      <= 1'b1;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end

                StData: begin
                    if (accept) begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            // Last lane goes straight into the write word, so
                            // the strobe appears the cycle after this edge.
                            state_q    <= StWrite;
                            byte_ready <= 1'b0;
                            mem_wren   <= 1'b1;
                            mem_addr   <= {word_idx_q[WIDX_W-1:0], 2'b00};
                            mem_din    <= {byte_in, lanes_q};
                        end else begin
                            lanes_q[8*byte_idx_q +: 8] <= byte_in;
                        end
                    end
                end

                StWrite: begin
                    word_idx_q <= word_idx_inc;
                    if (word_idx_inc == len_q) begin
                        state_q   <= StDone;
                        core_hold <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state_q    <= StData;
                        byte_ready <= 1'b1;
                    end
                end

                default: begin
                    state_q    <= StIdle;
                    byte_ready <= 1'b0;
                    core_hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream writer for the instruction memory. The core only reads the instruction memory; this block drives the memory's write port (ADDR/DIN/wren) to load a program.
- Accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words to consecutive word addresses from 0, holding the core in reset while loading.
- Sits between a serial/host byte source and the instruction memory write port plus the core's clear input.

Parameters:
ADDR_WIDTH, 8, byte-address width of instruction memory; capacity = 2**(ADDR_WIDTH-2) words (64 at default)
LEN_WIDTH, 16, width of the word-count header field (sent as 2 bytes, LSB first)

Ports:
clock  input  1  system clock, rising-edge
clear  input  1  asynchronous, active-high reset
start  input  1  pulse; begins a load session when IDLE, DONE or ERR
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader can accept a byte this cycle
mem_addr  output  ADDR_WIDTH  instruction memory byte address (word aligned)
mem_din  output  32  word to write, {b3,b2,b1,b0}
mem_wren  output  1  write strobe to instruction memory, one cycle per word
core_hold  output  1  drives core clear; high while a session is active
done  output  1  load completed successfully; sticky until next start
error  output  1  header word count exceeds capacity; sticky until next start

Behaviour:
- Reset (clear=1, asynchronous): state IDLE; byte_ready=0; mem_wren=0; mem_addr=0; mem_din=0; core_hold=0; done=0; error=0; internal counters=0.
- A byte is accepted on a rising clock edge when byte_valid&&byte_ready. A byte is never consumed while byte_ready=0.
- The source holds byte_in stable while byte_valid=1 and byte_ready=0.
- byte_ready=1 only in LEN_LO, LEN_HI and DATA; it is a registered/state-decoded output, 0 in all other states.
- States and transitions:
  - IDLE: on start, go to LEN_LO; core_hold<=1; done<=0; error<=0; word index<=0; byte index<=0.
  - LEN_LO: accept byte -> len[7:0]; go to LEN_HI.
  - LEN_HI: accept byte -> len[15:8].
    - len==0: go to DONE.
    - len>2**(ADDR_WIDTH-2): go to ERR.
    - Otherwise: go to DATA.
  - DATA: each accepted byte is stored in lane byte index (0..3); byte index increments mod 4. On accepting lane 3, go to WRITE.
  - WRITE: exactly one cycle.
    - mem_wren=1; mem_addr=word index*4; mem_din=assembled word.
    - Word index increments at the end of the cycle.
    - If the incremented index equals len, go to DONE; otherwise go back to DATA.
  - DONE: core_hold<=0; done<=1. On start, restart at LEN_LO with the same actions as from IDLE.
  - ERR: core_hold<=0; error<=1; no memory writes. On start, restart at LEN_LO.
- start is ignored in LEN_LO, LEN_HI, DATA and WRITE.
- Latency: mem_wren asserts in the cycle immediately after the edge that accepted the 4th byte of a word. Minimum cost is 5 cycles per word with a continuous stream.
- Outputs are driven from registers. mem_addr and mem_din are stable throughout the wren cycle; mem_wren=0 in every non-WRITE state.
- Address wrap cannot occur, because the length check guarantees word index < capacity. A full-capacity load (len=64) writes 0x00..0xFC.
- Gaps in byte_valid only stall the state machine; no timeout.
- Reset mid-session: all outputs return to reset values immediately, including core_hold=0. Partially written memory contents are not restored.
- done and error are mutually exclusive; at most one is set per session.

Test Plan:
- Continuous stream, start pulse, then bytes 02 00 93 00 10 00 13 01 20 00 -> two writes:
  - addr 0x00, din 0x00100093;
  - addr 0x04, din 0x00200113.
  - Then done=1, core_hold=0, mem_wren high exactly 2 cycles total.
- Backpressure: byte_valid held high continuously with the same stream -> no byte lost or duplicated across the WRITE cycles (byte_ready=0 there); same two writes.
- Header 41 00 (65 words) -> error=1, done=0, mem_wren never asserted, byte_ready=0 afterward.
- Header 00 00 -> done=1 on the cycle after LEN_HI is accepted, zero writes.
- Header 40 00 plus 256 bytes -> 64 writes, last at addr 0xFC; done=1.
- Reset mid-load: assert clear after 6 data bytes -> all outputs 0 asynchronously. A new start then reloads from addr 0; start pulses during DATA are ignored.
